dmem_bridge: RTL and testbench

Data-memory bridge directly downstream of the datapath's memory stage. It converts the stage's single-cycle access (word address, big-endian byte-lane write mask, write data, full-word read data) into a request/response bus with arbitrary latency. While a transfer is outstanding it stalls the pipeline. Sub-word load extraction and sign extension stay in write-back; the bridge always returns the full aligned word.

---
 rtl/dmem_bridge_pkg.sv | 21 ++
 rtl/dmem_bridge_if.sv | 28 ++
 rtl/dmem_wbuf.sv | 60 ++++++
 rtl/dmem_bridge.sv | 127 ++++++++++++
 tb/tb_dmem_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and constants for the data-memory bridge.
//   state_e    - main access FSM (IDLE -> WAIT -> DONE)
//   wb_state_e - posted write buffer FSM (EMPTY -> REQ -> PEND)
//   BE_ALL     - full-word byte-lane mask used for loads
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_REQ   = 2'd1,
    WB_PEND  = 2'd2
  } wb_state_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: request/response data bus between the bridge (master)
// and the memory system (slave).
//   req/wr/be/addr/wdata - request channel, valid while req is high
//   addr_ok              - request accepted this cycle (qualified by req)
//   data_ok/rdata        - response: read data valid or write complete
// Byte enables use big-endian lane order: be[3] = byte offset 0 = data[31:24].
interface dmem_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  wr;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [31:0]           rdata;

  modport master (
    output req, wr, be, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, be, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted write buffer. A push captures a store and the
// buffer then owns the bus until that write completes.
//   clk, rst          - clock, synchronous active-high reset
//   push              - capture push_* (only honoured while empty)
//   push_addr/be/wdata- word-aligned store request
//   addr_ok, data_ok  - bus handshakes, only observed in REQ / PEND
//   busy              - buffer holds a write (not yet data_ok'd)
//   req, addr, be, wdata - bus request fields while busy
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [3:0]            push_be,
  input  logic [31:0]           push_wdata,
  input  logic                  addr_ok,
  input  logic                  data_ok,
  output logic                  busy,
  output logic                  req,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [3:0]            be,
  output logic [31:0]           wdata
);

  wb_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_EMPTY: if (push)    state_d = WB_REQ;
      WB_REQ:   if (addr_ok) state_d = WB_PEND;
      WB_PEND:  if (data_ok) state_d = WB_EMPTY;
      default:               state_d = WB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= WB_EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: the payload needs no reset; it is only observed while state_q says
  // the entry is valid, and leaving it out keeps the reset net small.
  always_ff @(posedge clk) begin
    if (state_q == WB_EMPTY && push) begin
      addr  <= push_addr;
      be    <= push_be;
      wdata <= push_wdata;
    end
  end

  // The entry stays busy through PEND so a following access cannot overtake it.
  assign busy = (state_q != WB_EMPTY);
  assign req  = (state_q == WB_REQ);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: converts the memory stage's single-cycle access into a
// request/response bus transfer, stalling the pipeline while it is in flight.
//   clk, rst   - pipeline clock, synchronous active-high reset
//   mem_en     - access valid; mem_wen == 0 means load, else store mask
//   mem_addr   - byte address (low two bits ignored, word aligned on the bus)
//   mem_wdata  - lane-replicated store data
//   mem_rdata  - registered full read word (captured on load data_ok)
//   mem_stall  - freeze the pipeline registers
//   bus        - dmem_bridge_if master port
// Build option: DMEM_BRIDGE_WBUF_EN adds a one-entry posted write buffer
// (dmem_wbuf) giving zero-stall stores; without it stores behave like loads.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic [3:0]            mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_stall,
  dmem_bridge_if.master         bus
);

  logic                  is_store;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [1:0]            unused_addr_lsb;

  assign is_store        = mem_en & (mem_wen != 4'b0000);
  assign word_addr       = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_addr_lsb = mem_addr[1:0];

  state_e state_q, state_d;
  logic   fsm_req;
  logic   load_q;

  // Write-buffer view seen by the main FSM and the bus mux.
  logic                  wb_busy;
  logic                  wb_req;
  logic                  post_store;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [3:0]            wb_be;
  logic [31:0]           wb_wdata;

`ifdef DMEM_BRIDGE_WBUF_EN
  // A store is posted only from IDLE into an empty buffer; otherwise it waits.
  assign post_store = is_store & ~wb_busy & (state_q == ST_IDLE);

  dmem_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (post_store),
    .push_addr  (word_addr),
    .push_be    (mem_wen),
    .push_wdata (mem_wdata),
    .addr_ok    (bus.addr_ok),
    .data_ok    (bus.data_ok),
    .busy       (wb_busy),
    .req        (wb_req),
    .addr       (wb_addr),
    .be         (wb_be),
    .wdata      (wb_wdata)
  );
`else
  assign post_store = 1'b0;
  assign wb_busy    = 1'b0;
  assign wb_req     = 1'b0;
  assign wb_addr    = '0;
  assign wb_be      = '0;
  assign wb_wdata   = '0;
`endif

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d   = state_q;
    fsm_req   = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_en && !post_store) begin
          mem_stall = 1'b1;
          // An older posted write must finish before anything new is issued.
          if (!wb_busy) begin
            fsm_req = 1'b1;
            if (bus.addr_ok) state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (bus.data_ok) state_d = ST_DONE;
      end
      // One non-stalled cycle lets the M stage advance without re-issuing.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst) mem_stall = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      load_q    <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && fsm_req && bus.addr_ok) load_q <= ~is_store;
      if (state_q == ST_WAIT && bus.data_ok && load_q)  mem_rdata <= bus.rdata;
    end
  end

  // The buffer owns the bus whenever it holds a write.
  assign bus.req   = ~rst & (wb_busy ? wb_req : fsm_req);
  assign bus.wr    = wb_busy ? 1'b1     : is_store;
  assign bus.be    = wb_busy ? wb_be    : (is_store ? mem_wen : BE_ALL);
  assign bus.addr  = wb_busy ? wb_addr  : word_addr;
  assign bus.wdata = wb_busy ? wb_wdata : mem_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: self-checking bench for dmem_bridge. A bus slave with
// programmable accept/response latency backs a word memory; a separate
// program-order memory model supplies expected load data.
module tb_dmem_bridge;

  localparam int AW    = 32;
  localparam int WORDS = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_stall;

  dmem_bridge_if #(.ADDR_WIDTH(AW)) bus_if ();

  dmem_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave state and memories.
  logic [31:0] ram       [WORDS];
  logic [31:0] model_mem [WORDS];
  int          cfg_a_dly, cfg_d_dly, a_cnt, d_cnt;
  bit          out_valid, force_data_ok;
  txn_t        out_txn;
  txn_t        issued [$];

  // Per-cycle observations.
  logic        obs_stall, obs_req, obs_acc;
  logic [31:0] obs_rdata;
  txn_t        obs_txn, exp_txn;
  int          req_cycles, bad_fields;

  function automatic int widx(logic [AW-1:0] a);
    return int'(a[7:2]);
  endfunction

  // be[k] enables data[8k+7:8k]; be[3] is byte offset 0.
  function automatic logic [31:0] merge(logic [31:0] old, logic [3:0] be, logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  task automatic set_in(bit en, logic [3:0] wen, logic [AW-1:0] a, logic [31:0] d);
    mem_en = en; mem_wen = wen; mem_addr = a; mem_wdata = d;
  endtask

  // One clock: entered and left at posedge+1.
  task automatic cycle();
    #1;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = 32'h0;
    if (force_data_ok) begin
      bus_if.data_ok = 1'b1; bus_if.rdata = 32'hDEAD_BEEF;
    end else if (out_valid) begin
      if (d_cnt == 0) begin
        bus_if.data_ok = 1'b1;
        bus_if.rdata   = out_txn.wr ? $urandom : ram[widx(out_txn.addr)];
      end
    end else if (bus_if.req && a_cnt >= cfg_a_dly) begin
      bus_if.addr_ok = 1'b1;
    end
    @(negedge clk);
    obs_stall = mem_stall; obs_req = bus_if.req; obs_rdata = mem_rdata;
    obs_acc   = bus_if.req && bus_if.addr_ok;
    obs_txn   = {bus_if.wr, bus_if.be, bus_if.addr, bus_if.wdata};
    if (obs_acc) issued.push_back(obs_txn);
    if (obs_req) begin
      req_cycles++;
      if (obs_txn != exp_txn) bad_fields++;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      out_valid = 1'b0; a_cnt = 0;
    end else begin
      if (obs_acc) begin
        out_valid = 1'b1; out_txn = obs_txn; d_cnt = cfg_d_dly; a_cnt = 0;
      end else if (obs_req) begin
        a_cnt++;
      end
      if (bus_if.data_ok && !force_data_ok) begin
        if (out_txn.wr) ram[widx(out_txn.addr)] = merge(ram[widx(out_txn.addr)], out_txn.be, out_txn.wdata);
        out_valid = 1'b0;
      end else if (out_valid && !obs_acc) begin
        d_cnt--;
      end
    end
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0;
  endtask

  // Present one access and hold it while stalled; returns stall count and
  // the mem_rdata seen in the completing (non-stalled) cycle.
  task automatic run_access(bit en, logic [3:0] wen, logic [AW-1:0] a, logic [31:0] d,
                            output int stalls, output logic [31:0] rd);
    set_in(en, wen, a, d);
    stalls = 0; rd = 32'h0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (!obs_stall) begin
        rd = obs_rdata;
        return;
      end
      stalls++;
    end
    n_checks++; n_fail++;
    $display("FAIL access_timeout: addr %h still stalled after 60 cycles, expected completion", a);
  endtask

  // Idle the pipeline until the bus and any posted write are quiet.
  task automatic drain();
    int quiet;
    quiet = 0;
    set_in(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 100 && quiet < 3; i++) begin
      cycle();
      if (!obs_req && !out_valid) quiet++;
      else quiet = 0;
    end
    n_checks++;
    if (quiet < 3) begin
      n_fail++;
      $display("FAIL drain_timeout: bus still busy after 100 cycles, expected idle");
    end
  endtask

  task automatic test_reset();
    set_in(1'b1, 4'b0000, 32'h13, 32'h0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if (obs_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", obs_stall); end
      n_checks++;
      if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", obs_req); end
    end
    rst = 1'b0;
    set_in(1'b0, 4'b0000, 32'h0, 32'h0);
    cycle();
    n_checks++;
    if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", obs_rdata); end
    n_checks++;
    if (obs_stall !== 1'b0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: stall %b req %b expected 0 0", obs_stall, obs_req);
    end
  endtask

  task automatic test_load_basic();
    int st; logic [31:0] rd; txn_t t;
    ram[4] = 32'hA1B2_C3D4; model_mem[4] = 32'hA1B2_C3D4;
    cfg_a_dly = 0; cfg_d_dly = 0; issued.delete();
    run_access(1'b1, 4'b0000, 32'h13, 32'h0, st, rd);
    n_checks++;
    if (st != 2) begin n_fail++; $display("FAIL load_stall: got %0d cycles expected 2", st); end
    n_checks++;
    if (rd !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL load_rdata: got %h expected a1b2c3d4", rd); end
    n_checks++;
    if (issued.size() != 1) begin n_fail++; $display("FAIL load_issue_count: got %0d expected 1", issued.size()); end
    t = (issued.size() > 0) ? issued[0] : '0;
    n_checks++;
    if (t.addr !== 32'h10 || t.be !== 4'b1111 || t.wr !== 1'b0) begin
      n_fail++; $display("FAIL load_fields: addr %h be %b wr %b expected 10 1111 0", t.addr, t.be, t.wr);
    end
  endtask

  task automatic test_store_delayed();
    int st, exp_st; logic [31:0] rd;
`ifdef DMEM_BRIDGE_WBUF_EN
    exp_st = 0;
`else
    exp_st = 5;
`endif
    cfg_a_dly = 3; cfg_d_dly = 0; issued.delete();
    exp_txn = {1'b1, 4'b0100, 32'h20, 32'h5A5A_5A5A};
    req_cycles = 0; bad_fields = 0;
    run_access(1'b1, 4'b0100, 32'h21, 32'h5A5A_5A5A, st, rd);
    model_mem[8] = merge(model_mem[8], 4'b0100, 32'h5A5A_5A5A);
    drain();
    n_checks++;
    if (st != exp_st) begin n_fail++; $display("FAIL sb_stall: got %0d cycles expected %0d", st, exp_st); end
    n_checks++;
    if (req_cycles != 4) begin n_fail++; $display("FAIL sb_req_cycles: got %0d expected 4", req_cycles); end
    n_checks++;
    if (bad_fields != 0) begin n_fail++; $display("FAIL sb_req_fields: %0d cycles differed from addr 20 be 0100", bad_fields); end
    n_checks++;
    if (issued.size() != 1) begin n_fail++; $display("FAIL sb_issue_count: got %0d expected 1", issued.size()); end
    n_checks++;
    if (ram[8] !== model_mem[8]) begin n_fail++; $display("FAIL sb_mem: got %h expected %h", ram[8], model_mem[8]); end
    n_checks++;
    if (rd !== 32'hA1B2_C3D4 || obs_rdata !== 32'hA1B2_C3D4) begin
      n_fail++; $display("FAIL sb_rdata_hold: got %h/%h expected a1b2c3d4", rd, obs_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] rd;
    cfg_a_dly = 0; cfg_d_dly = 5;
    set_in(1'b1, 4'b0000, 32'h30, 32'h0);
    cycle();
    cycle();
    n_checks++;
    if (obs_stall !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stall: got %b expected 1", obs_stall); end
    rst = 1'b1;
    cycle();
    n_checks++;
    if (obs_stall !== 1'b0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_during: stall %b req %b expected 0 0", obs_stall, obs_req);
    end
    rst = 1'b0;
    set_in(1'b0, 4'b0000, 32'h0, 32'h0);
    cycle();
    n_checks++;
    if (obs_stall !== 1'b0 || obs_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: stall %b req %b expected 0 0", obs_stall, obs_req);
    end
    force_data_ok = 1'b1;
    cycle();
    force_data_ok = 1'b0;
    cycle();
    n_checks++;
    if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_stale_data: got %h expected 0", obs_rdata); end
    cfg_d_dly = 0;
    run_access(1'b1, 4'b0000, 32'h30, 32'h0, st, rd);
    n_checks++;
    if (st != 2 || rd !== model_mem[12]) begin
      n_fail++; $display("FAIL rstmid_recover: stall %0d rdata %h expected 2 %h", st, rd, model_mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] rd;
    cfg_a_dly = 0; cfg_d_dly = 2; issued.delete();
    for (int i = 0; i < 2; i++) begin
      logic [AW-1:0] a;
      a = 32'h44 + 32'(4 * i);
      run_access(1'b1, 4'b0000, a, 32'h0, st, rd);
      n_checks++;
      if (st != 4) begin n_fail++; $display("FAIL b2b_stall%0d: got %0d expected 4", i, st); end
      n_checks++;
      if (rd !== model_mem[widx(a)]) begin n_fail++; $display("FAIL b2b_rdata%0d: got %h expected %h", i, rd, model_mem[widx(a)]); end
    end
    n_checks++;
    if (issued.size() != 2) begin n_fail++; $display("FAIL b2b_issue_count: got %0d expected 2", issued.size()); end
  endtask

  task automatic test_store_then_load();
    int st_w, st_r, exp_w, exp_r; logic [31:0] rd; txn_t t0, t1;
`ifdef DMEM_BRIDGE_WBUF_EN
    exp_w = 0; exp_r = 4;
`else
    exp_w = 2; exp_r = 2;
`endif
    drain();
    cfg_a_dly = 0; cfg_d_dly = 0; issued.delete();
    run_access(1'b1, 4'b1111, 32'h40, 32'h1122_3344, st_w, rd);
    model_mem[16] = 32'h1122_3344;
    run_access(1'b1, 4'b0000, 32'h40, 32'h0, st_r, rd);
    n_checks++;
    if (st_w != exp_w) begin n_fail++; $display("FAIL sw_stall: got %0d expected %0d", st_w, exp_w); end
    n_checks++;
    if (st_r != exp_r) begin n_fail++; $display("FAIL lw_after_sw_stall: got %0d expected %0d", st_r, exp_r); end
    n_checks++;
    if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL lw_after_sw_rdata: got %h expected 11223344", rd); end
    t0 = (issued.size() > 0) ? issued[0] : '0;
    t1 = (issued.size() > 1) ? issued[1] : '0;
    n_checks++;
    if (issued.size() != 2 || t0.wr !== 1'b1 || t0.be !== 4'b1111 || t0.addr !== 32'h40 || t1.wr !== 1'b0) begin
      n_fail++; $display("FAIL sw_lw_order: n %0d first wr %b be %b addr %h second wr %b expected 2 1 1111 40 0",
                         issued.size(), t0.wr, t0.be, t0.addr, t1.wr);
    end
  endtask

  task automatic test_random();
    logic [3:0] masks [7];
    int st, n_acc, mi, bad;
    logic [31:0] rd, d;
    logic [AW-1:0] a;
    logic [3:0] wen;
    bit en, ld;
    masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    drain();
    issued.delete(); n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      en = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 1) != 0);
      mi = $urandom_range(0, 6);
      wen = ld ? 4'b0000 : masks[mi];
      a = $urandom_range(0, 255);
      d = $urandom;
      cfg_a_dly = $urandom_range(0, 3);
      cfg_d_dly = $urandom_range(0, 3);
      run_access(en, wen, a, d, st, rd);
      if (en) begin
        n_acc++;
        if (!ld) model_mem[widx(a)] = merge(model_mem[widx(a)], wen, d);
      end
`ifndef DMEM_BRIDGE_WBUF_EN
      n_checks++;
      if (st != (en ? cfg_a_dly + cfg_d_dly + 2 : 0)) begin
        n_fail++; $display("FAIL rand_stall%0d: got %0d expected %0d", i, st, en ? cfg_a_dly + cfg_d_dly + 2 : 0);
      end
`endif
      if (en && ld) begin
        n_checks++;
        if (rd !== model_mem[widx(a)]) begin
          n_fail++; $display("FAIL rand_rdata%0d: addr %h got %h expected %h", i, a, rd, model_mem[widx(a)]);
        end
      end
    end
    drain();
    n_checks++;
    if (issued.size() != n_acc) begin n_fail++; $display("FAIL rand_issue_count: got %0d expected %0d", issued.size(), n_acc); end
    bad = 0;
    for (int w = 0; w < WORDS; w++) if (ram[w] !== model_mem[w]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL rand_final_mem: %0d words differ, expected 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 4'b0000, 32'h0, 32'h0);
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = 32'h0;
    force_data_ok = 1'b0; out_valid = 1'b0; out_txn = '0;
    a_cnt = 0; d_cnt = 0; cfg_a_dly = 0; cfg_d_dly = 0;
    obs_stall = 1'b0; obs_req = 1'b0; obs_acc = 1'b0; obs_rdata = 32'h0; obs_txn = '0;
    exp_txn = '0; req_cycles = 0; bad_fields = 0;
    for (int i = 0; i < WORDS; i++) begin
      ram[i] = $urandom;
      model_mem[i] = ram[i];
    end
    @(posedge clk);
    #1;
    test_reset();
    test_load_basic();
    test_store_delayed();
    test_reset_mid();
    test_back_to_back();
    test_store_then_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
